// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data RAM, memory-mapped timer/LED/digit/systick
// registers, load formatting, write-back select and the timer interrupt request.
module mem_stage #(
  parameter int unsigned RAM_ADDR_W = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic [31:0] ALUOut_MEM,
  input  logic [31:0] rt_MEM,
  input  logic        LoadByte_MEM,
  input  logic [1:0]  MemtoReg_MEM,
  input  logic [31:0] PC_MEM,
  output logic [31:0] MemData_MEM,
  output logic [31:0] WriteData_MEM,
  output logic [7:0]  leds,
  output logic [11:0] digits,
  output logic        irq
);

  localparam int unsigned Depth = 2 ** RAM_ADDR_W;

  // Word offsets (byte offset >> 2) inside the peripheral window.
  localparam logic [5:0] WOffTh      = 6'h00;
  localparam logic [5:0] WOffTl      = 6'h01;
  localparam logic [5:0] WOffTcon    = 6'h02;
  localparam logic [5:0] WOffLeds    = 6'h03;
  localparam logic [5:0] WOffDigits  = 6'h04;
  localparam logic [5:0] WOffSystick = 6'h05;

  logic [31:0] ram_q [Depth];

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  leds_q, leds_d;
  logic [11:0] digits_q, digits_d;
  logic [31:0] systick_q, systick_d;

  logic                  is_mmio;
  logic [5:0]            mmio_woff;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic                  mmio_wr;
  logic                  ram_wr;
  logic [31:0]           mmio_rdata;
  logic [31:0]           word_rdata;
  logic [7:0]            byte_rdata;
  logic [31:0]           load_data;

  assign is_mmio   = (ALUOut_MEM[31:28] == MMIO_BASE[31:28]);
  assign mmio_woff = ALUOut_MEM[7:2];
  assign ram_idx   = ALUOut_MEM[RAM_ADDR_W+1:2];
  assign mmio_wr   = MemWrite_MEM & is_mmio;
  assign ram_wr    = MemWrite_MEM & ~is_mmio;

  // Register next state: timer/systick first, then software writes take priority.
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    leds_d    = leds_q;
    digits_d  = digits_q;
    systick_d = systick_q + 32'd1;

    if (tcon_q[0]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d      = th_q;
        tcon_d[2] = tcon_q[1] | tcon_q[2];
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end

    if (mmio_wr) begin
      case (mmio_woff)
        WOffTh:     th_d     = rt_MEM;
        WOffTl:     tl_d     = rt_MEM;
        WOffTcon:   tcon_d   = rt_MEM[2:0];
        WOffLeds:   leds_d   = rt_MEM[7:0];
        WOffDigits: digits_d = rt_MEM[11:0];
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      leds_q    <= '0;
      digits_q  <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      leds_q    <= leds_d;
      digits_q  <= digits_d;
      systick_q <= systick_d;
    end
  end

  // RAM is never cleared; stores during reset are dropped.
  always_ff @(posedge clk) begin
    if (reset && ram_wr) begin
      ram_q[ram_idx] <= rt_MEM;
    end
  end

  always_comb begin
    mmio_rdata = '0;
    case (mmio_woff)
      WOffTh:      mmio_rdata = th_q;
      WOffTl:      mmio_rdata = tl_q;
      WOffTcon:    mmio_rdata = {29'd0, tcon_q};
      WOffLeds:    mmio_rdata = {24'd0, leds_q};
      WOffDigits:  mmio_rdata = {20'd0, digits_q};
      WOffSystick: mmio_rdata = systick_q;
      default:     mmio_rdata = '0;
    endcase
  end

  always_comb begin
    word_rdata = is_mmio ? mmio_rdata : ram_q[ram_idx];
    byte_rdata = word_rdata[{ALUOut_MEM[1:0], 3'b000} +: 8];
    load_data  = LoadByte_MEM ? {{24{byte_rdata[7]}}, byte_rdata} : word_rdata;
    MemData_MEM = MemRead_MEM ? load_data : 32'd0;
  end

  always_comb begin
    WriteData_MEM = ALUOut_MEM;
    case (MemtoReg_MEM)
      2'b01:   WriteData_MEM = MemData_MEM;
      2'b10:   WriteData_MEM = PC_MEM + 32'd4;
      default: WriteData_MEM = ALUOut_MEM;
    endcase
  end

  assign leds   = leds_q;
  assign digits = digits_q;
  assign irq    = tcon_q[2];

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: RAM loads/stores, MMIO registers, timer, reset and write-back mux.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_MEM, MemWrite_MEM, LoadByte_MEM;
  logic [31:0] ALUOut_MEM, rt_MEM, PC_MEM;
  logic [1:0]  MemtoReg_MEM;
  logic [31:0] MemData_MEM, WriteData_MEM;
  logic [7:0]  leds;
  logic [11:0] digits;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] tb_tick;

  mem_stage dut (
    .clk          (clk),
    .reset        (reset),
    .MemRead_MEM  (MemRead_MEM),
    .MemWrite_MEM (MemWrite_MEM),
    .ALUOut_MEM   (ALUOut_MEM),
    .rt_MEM       (rt_MEM),
    .LoadByte_MEM (LoadByte_MEM),
    .MemtoReg_MEM (MemtoReg_MEM),
    .PC_MEM       (PC_MEM),
    .MemData_MEM  (MemData_MEM),
    .WriteData_MEM(WriteData_MEM),
    .leds         (leds),
    .digits       (digits),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Reference systick: counts non-reset edges.
  always @(posedge clk) begin
    if (!reset) tb_tick <= 32'd0;
    else        tb_tick <= tb_tick + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sw(input logic [31:0] addr, input logic [31:0] data);
    MemWrite_MEM = 1'b1;
    ALUOut_MEM   = addr;
    rt_MEM       = data;
    tick();
    MemWrite_MEM = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic lb, output logic [31:0] data);
    MemRead_MEM  = 1'b1;
    LoadByte_MEM = lb;
    ALUOut_MEM   = addr;
    #1;
    data = MemData_MEM;
    MemRead_MEM  = 1'b0;
    LoadByte_MEM = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    reset        = 1'b0;
    MemRead_MEM  = 1'b0;
    MemWrite_MEM = 1'b0;
    LoadByte_MEM = 1'b0;
    ALUOut_MEM   = 32'd0;
    rt_MEM       = 32'd0;
    PC_MEM       = 32'd0;
    MemtoReg_MEM = 2'b00;
    repeat (2) tick();
    reset = 1'b1;

    // Reset state
    chk("rst_leds", {24'd0, leds}, 32'd0);
    chk("rst_digits", {20'd0, digits}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(32'h4000_0004, 1'b0, v); chk("rst_tl", v, 32'd0);
    #1 chk("rd_idle_zero", MemData_MEM, 32'd0);

    // RAM word / byte loads
    sw(32'h0000_0010, 32'hA1B2_C3D4);
    rd(32'h0000_0010, 1'b0, v); chk("lw_10", v, 32'hA1B2_C3D4);
    rd(32'h0000_0013, 1'b0, v); chk("lw_13_aligned", v, 32'hA1B2_C3D4);
    rd(32'h0000_0011, 1'b1, v); chk("lb_11", v, 32'hFFFF_FFC3);
    rd(32'h0000_0013, 1'b1, v); chk("lb_13", v, 32'hFFFF_FFA1);
    rd(32'h0000_0010, 1'b1, v); chk("lb_10", v, 32'hFFFF_FFD4);
    rd(32'h0000_0410, 1'b0, v); chk("lw_alias", v, 32'hA1B2_C3D4);
    sw(32'h0000_0020, 32'h0000_7F00);
    rd(32'h0000_0021, 1'b1, v); chk("lb_pos", v, 32'h0000_007F);
    rd(32'h0000_0020, 1'b1, v); chk("lb_zero", v, 32'h0000_0000);

    // Write-back select
    PC_MEM = 32'h0040_0020;
    ALUOut_MEM = 32'h1234_5678;
    MemtoReg_MEM = 2'b10; #1 chk("wb_pc4", WriteData_MEM, 32'h0040_0024);
    MemtoReg_MEM = 2'b00; #1 chk("wb_alu", WriteData_MEM, 32'h1234_5678);
    MemtoReg_MEM = 2'b11; #1 chk("wb_11_alu", WriteData_MEM, 32'h1234_5678);
    MemtoReg_MEM = 2'b01;
    ALUOut_MEM = 32'h0000_0010;
    MemRead_MEM = 1'b1;
    #1 chk("wb_mem", WriteData_MEM, 32'hA1B2_C3D4);
    MemRead_MEM = 1'b0;
    MemtoReg_MEM = 2'b00;

    // Timer reload and sticky irq
    sw(32'h4000_0000, 32'hFFFF_FFFE);
    sw(32'h4000_0004, 32'hFFFF_FFFE);
    sw(32'h4000_0008, 32'h0000_0003);
    rd(32'h4000_0004, 1'b0, v); chk("tl_start", v, 32'hFFFF_FFFE);
    rd(32'h4000_0001, 1'b1, v); chk("lb_th_byte1", v, 32'hFFFF_FFFF);
    tick();
    rd(32'h4000_0004, 1'b0, v); chk("tl_max", v, 32'hFFFF_FFFF);
    chk("irq_before", {31'd0, irq}, 32'd0);
    tick();
    rd(32'h4000_0004, 1'b0, v); chk("tl_reload", v, 32'hFFFF_FFFE);
    chk("irq_set", {31'd0, irq}, 32'd1);
    rd(32'h4000_0008, 1'b0, v); chk("tcon_rd", v, 32'h0000_0007);
    sw(32'h4000_0008, 32'h0000_0003);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_again", {31'd0, irq}, 32'd1);
    tick();
    chk("irq_sticky", {31'd0, irq}, 32'd1);
    sw(32'h4000_0008, 32'h0000_0000);
    chk("irq_off", {31'd0, irq}, 32'd0);

    // LEDs, digits, systick, unmapped
    sw(32'h4000_000C, 32'h0000_005A);
    chk("leds", {24'd0, leds}, 32'h0000_005A);
    sw(32'h4000_0010, 32'h000A_BCDE);
    chk("digits", {20'd0, digits}, 32'h0000_0CDE);
    sw(32'h4000_0014, 32'h0000_0000);
    rd(32'h4000_0014, 1'b0, v); chk("systick_ro", v, tb_tick);
    tick(); tick();
    rd(32'h4000_0014, 1'b0, v); chk("systick_cnt", v, tb_tick);
    sw(32'h4000_0018, 32'hFFFF_FFFF);
    rd(32'h4000_0018, 1'b0, v); chk("unmapped", v, 32'd0);
    chk("leds_keep", {24'd0, leds}, 32'h0000_005A);

    // Read-during-write returns old data
    sw(32'h0000_0030, 32'h1111_1111);
    MemRead_MEM = 1'b1;
    MemWrite_MEM = 1'b1;
    ALUOut_MEM = 32'h0000_0030;
    rt_MEM = 32'h2222_2222;
    #1 chk("rdw_old", MemData_MEM, 32'h1111_1111);
    tick();
    MemWrite_MEM = 1'b0;
    chk("rdw_new", MemData_MEM, 32'h2222_2222);
    MemRead_MEM = 1'b0;

    // Reset mid-count; store during reset is dropped
    sw(32'h4000_0004, 32'h0000_0005);
    sw(32'h4000_0008, 32'h0000_0003);
    reset = 1'b0;
    MemWrite_MEM = 1'b1;
    ALUOut_MEM = 32'h0000_0010;
    rt_MEM = 32'hDEAD_BEEF;
    tick();
    reset = 1'b1;
    MemWrite_MEM = 1'b0;
    chk("rst2_leds", {24'd0, leds}, 32'd0);
    chk("rst2_digits", {20'd0, digits}, 32'd0);
    chk("rst2_irq", {31'd0, irq}, 32'd0);
    rd(32'h4000_0014, 1'b0, v); chk("rst2_systick", v, 32'd0);
    rd(32'h4000_0008, 1'b0, v); chk("rst2_tcon", v, 32'd0);
    rd(32'h0000_0010, 1'b0, v); chk("rst2_ram", v, 32'hA1B2_C3D4);
    tick();
    rd(32'h4000_0004, 1'b0, v); chk("rst2_tl_idle", v, 32'd0);
    rd(32'h4000_0014, 1'b0, v); chk("rst2_systick_run", v, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
